// File: rtl/wb_arbiter.sv
// wb_arbiter: two-requester writeback arbiter with a register scoreboard.
// Requester A is the ALU writeback path and requester B is the load/multicycle
// unit. A granted request is written to the register bank one cycle later.
// The Busy scoreboard tracks registers that have a write outstanding.
//
// Configuration macro: WB_ROUND_ROBIN_EN
//   undefined - fixed priority, A wins every contention (B may starve)
//   defined   - a 1-bit round-robin pointer alternates the preferred requester
module wb_arbiter (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqA_Valid,
    input  logic [4:0]  ReqA_Rg,
    input  logic [31:0] ReqA_Data,
    output logic        ReqA_Ready,
    input  logic        ReqB_Valid,
    input  logic [4:0]  ReqB_Rg,
    input  logic [31:0] ReqB_Data,
    output logic        ReqB_Ready,
    input  logic        MarkValid,
    input  logic [4:0]  MarkRg,
    output logic        RegWrite,
    output logic [4:0]  WriteRg,
    output logic [31:0] WriteData,
    output logic [31:0] Busy
);

`ifdef WB_ROUND_ROBIN_EN
    typedef enum logic {
        PREF_A = 1'b0,
        PREF_B = 1'b1
    } pref_e;

    pref_e       ptr_q;
`endif

    logic        grant_a_s;
    logic        grant_b_s;
    logic        grant_s;
    logic [4:0]  grant_rg_s;
    logic [31:0] grant_data_s;

    logic [31:0] clr_mask_s;
    logic [31:0] set_mask_s;

    logic        regwrite_d;
    logic        regwrite_q;
    logic [4:0]  writerg_d;
    logic [4:0]  writerg_q;
    logic [31:0] writedata_d;
    logic [31:0] writedata_q;
    logic [31:0] busy_d;
    logic [31:0] busy_q;

    // Arbitration: at most one grant per cycle, none while Reset is high.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (Reset) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else if (ReqA_Valid && ReqB_Valid) begin
`ifdef WB_ROUND_ROBIN_EN
            if (ptr_q == PREF_B) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b1;
            end
`else
            grant_a_s = 1'b1;
`endif
        end else begin
            grant_a_s = ReqA_Valid;
            grant_b_s = ReqB_Valid;
        end
    end

    assign ReqA_Ready   = grant_a_s;
    assign ReqB_Ready   = grant_b_s;
    assign grant_s      = grant_a_s | grant_b_s;
    assign grant_rg_s   = grant_b_s ? ReqB_Rg   : ReqA_Rg;
    assign grant_data_s = grant_b_s ? ReqB_Data : ReqA_Data;

    // Next-state for the write port and the scoreboard; a mark beats a clear.
    always_comb begin
        clr_mask_s  = 32'd0;
        set_mask_s  = 32'd0;
        regwrite_d  = 1'b0;
        writerg_d   = writerg_q;
        writedata_d = writedata_q;
        busy_d      = busy_q;

        if (grant_s && (grant_rg_s != 5'd0)) begin
            clr_mask_s = 32'd1 << grant_rg_s;
        end else begin
            clr_mask_s = 32'd0;
        end

        if (MarkValid && (MarkRg != 5'd0)) begin
            set_mask_s = 32'd1 << MarkRg;
        end else begin
            set_mask_s = 32'd0;
        end

        if (grant_s) begin
            // Register 0 is accepted but never written.
            regwrite_d  = (grant_rg_s != 5'd0);
            writerg_d   = grant_rg_s;
            writedata_d = grant_data_s;
        end else begin
            regwrite_d  = 1'b0;
            writerg_d   = writerg_q;
            writedata_d = writedata_q;
        end

        busy_d = ((busy_q & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
    end

    // State registers: write port, scoreboard and (optionally) the RR pointer.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            regwrite_q  <= 1'b0;
            writerg_q   <= 5'd0;
            writedata_q <= 32'd0;
            busy_q      <= 32'd0;
`ifdef WB_ROUND_ROBIN_EN
            ptr_q       <= PREF_A;
`endif
        end else begin
            regwrite_q  <= regwrite_d;
            writerg_q   <= writerg_d;
            writedata_q <= writedata_d;
            busy_q      <= busy_d;
`ifdef WB_ROUND_ROBIN_EN
            // After any grant the other requester becomes preferred.
            case ({grant_a_s, grant_b_s})
                2'b10:   ptr_q <= PREF_B;
                2'b01:   ptr_q <= PREF_A;
                default: ptr_q <= ptr_q;
            endcase
`endif
        end
    end

    assign RegWrite  = regwrite_q;
    assign WriteRg   = writerg_q;
    assign WriteData = writedata_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter. Inputs change 1 ns after the rising
// edge; registered outputs are sampled at that point (before new drive) and
// the combinational Ready outputs 1 ns after the drive.
module tb_wb_arbiter;

    logic        Clock;
    logic        Reset;
    logic        ReqA_Valid;
    logic [4:0]  ReqA_Rg;
    logic [31:0] ReqA_Data;
    logic        ReqA_Ready;
    logic        ReqB_Valid;
    logic [4:0]  ReqB_Rg;
    logic [31:0] ReqB_Data;
    logic        ReqB_Ready;
    logic        MarkValid;
    logic [4:0]  MarkRg;
    logic        RegWrite;
    logic [4:0]  WriteRg;
    logic [31:0] WriteData;
    logic [31:0] Busy;

    int vectors;
    int miscompares;

    wb_arbiter dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .ReqA_Valid (ReqA_Valid),
        .ReqA_Rg    (ReqA_Rg),
        .ReqA_Data  (ReqA_Data),
        .ReqA_Ready (ReqA_Ready),
        .ReqB_Valid (ReqB_Valid),
        .ReqB_Rg    (ReqB_Rg),
        .ReqB_Data  (ReqB_Data),
        .ReqB_Ready (ReqB_Ready),
        .MarkValid  (MarkValid),
        .MarkRg     (MarkRg),
        .RegWrite   (RegWrite),
        .WriteRg    (WriteRg),
        .WriteData  (WriteData),
        .Busy       (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        ReqA_Valid = 1'b0; ReqA_Rg = 5'd0; ReqA_Data = 32'd0;
        ReqB_Valid = 1'b0; ReqB_Rg = 5'd0; ReqB_Data = 32'd0;
        MarkValid  = 1'b0; MarkRg  = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Reset values, and Ready/Mark suppression while Reset is high.
    task automatic test_reset();
        Reset = 1'b1;
        idle_inputs();
        tick();
        ReqA_Valid = 1'b1; ReqA_Rg = 5'd3; ReqA_Data = 32'h0000_0033;
        ReqB_Valid = 1'b1; ReqB_Rg = 5'd4;
        MarkValid  = 1'b1; MarkRg  = 5'd6;
        #1;
        vectors++;
        if ({ReqA_Ready, ReqB_Ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 00", {ReqA_Ready, ReqB_Ready});
        end
        tick();
        vectors++;
        if ({RegWrite, WriteRg, WriteData, Busy} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got rw=%b rg=%0d data=%h busy=%h expected all zero",
                     RegWrite, WriteRg, WriteData, Busy);
        end
        idle_inputs();
    endtask

    // Single A request granted in the first cycle out of reset.
    task automatic test_single_a();
        Reset = 1'b0;
        ReqA_Valid = 1'b1; ReqA_Rg = 5'd5; ReqA_Data = 32'h0000_00AA;
        #1;
        vectors++;
        if ({ReqA_Ready, ReqB_Ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_a_ready: got %b expected 10", {ReqA_Ready, ReqB_Ready});
        end
        tick();
        idle_inputs();
        vectors++;
        if ({RegWrite, WriteRg, WriteData} !== {1'b1, 5'd5, 32'h0000_00AA}) begin
            miscompares++;
            $display("FAIL single_a_write: got rw=%b rg=%0d data=%h expected rw=1 rg=5 data=000000aa",
                     RegWrite, WriteRg, WriteData);
        end
        #1;
        vectors++;
        if (ReqA_Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_a_novalid_ready: got %b expected 0", ReqA_Ready);
        end
        tick();
        vectors++;
        if ({RegWrite, WriteRg, WriteData} !== {1'b0, 5'd5, 32'h0000_00AA}) begin
            miscompares++;
            $display("FAIL single_a_hold: got rw=%b rg=%0d data=%h expected rw=0 rg=5 data=000000aa",
                     RegWrite, WriteRg, WriteData);
        end
    endtask

    // Mark r7, then B writes r7 three cycles later and clears it.
    task automatic test_mark_clear();
        do_reset();
        MarkValid = 1'b1; MarkRg = 5'd7;
        tick();
        MarkValid = 1'b0; MarkRg = 5'd0;
        for (int c = 1; c <= 3; c++) begin
            vectors++;
            if (Busy !== 32'h0000_0080) begin
                miscompares++;
                $display("FAIL mark_busy_c%0d: got %h expected 00000080", c, Busy);
            end
            if (c == 3) begin
                ReqB_Valid = 1'b1; ReqB_Rg = 5'd7; ReqB_Data = 32'h0000_1234;
                #1;
                vectors++;
                if ({ReqA_Ready, ReqB_Ready} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL mark_b_ready: got %b expected 01", {ReqA_Ready, ReqB_Ready});
                end
            end
            tick();
        end
        idle_inputs();
        vectors++;
        if ({RegWrite, WriteRg, WriteData, Busy} !== {1'b1, 5'd7, 32'h0000_1234, 32'd0}) begin
            miscompares++;
            $display("FAIL mark_clear: got rw=%b rg=%0d data=%h busy=%h expected rw=1 rg=7 data=00001234 busy=0",
                     RegWrite, WriteRg, WriteData, Busy);
        end
    endtask

    // Both requesters valid for four cycles: back-to-back writes, no bubble.
    task automatic test_contention();
        logic exp_a;
        do_reset();
        ReqA_Valid = 1'b1; ReqA_Rg = 5'd1; ReqA_Data = 32'hA000_0001;
        ReqB_Valid = 1'b1; ReqB_Rg = 5'd2; ReqB_Data = 32'hB000_0002;
        for (int i = 0; i < 4; i++) begin
`ifdef WB_ROUND_ROBIN_EN
            exp_a = ((i % 2) == 0);
`else
            exp_a = 1'b1;
`endif
            #1;
            vectors++;
            if ({ReqA_Ready, ReqB_Ready} !== {exp_a, ~exp_a}) begin
                miscompares++;
                $display("FAIL contention_ready_%0d: got %b expected %b", i,
                         {ReqA_Ready, ReqB_Ready}, {exp_a, ~exp_a});
            end
            tick();
            vectors++;
            if ({RegWrite, WriteRg} !== {1'b1, (exp_a ? 5'd1 : 5'd2)}) begin
                miscompares++;
                $display("FAIL contention_write_%0d: got rw=%b rg=%0d expected rw=1 rg=%0d", i,
                         RegWrite, WriteRg, (exp_a ? 1 : 2));
            end
        end
        idle_inputs();
    endtask

    // Mark and clear of the same register at one edge; MarkRg=0 ignored.
    task automatic test_mark_collision();
        do_reset();
        MarkValid = 1'b1; MarkRg = 5'd9;
        tick();
        vectors++;
        if (Busy !== 32'h0000_0200) begin
            miscompares++;
            $display("FAIL collision_pre: got %h expected 00000200", Busy);
        end
        ReqA_Valid = 1'b1; ReqA_Rg = 5'd9; ReqA_Data = 32'h0000_0999;
        tick();
        MarkValid = 1'b0; MarkRg = 5'd0;
        vectors++;
        if ({RegWrite, WriteRg, Busy} !== {1'b1, 5'd9, 32'h0000_0200}) begin
            miscompares++;
            $display("FAIL collision_mark_wins: got rw=%b rg=%0d busy=%h expected rw=1 rg=9 busy=00000200",
                     RegWrite, WriteRg, Busy);
        end
        tick();
        ReqA_Valid = 1'b0;
        vectors++;
        if (Busy !== 32'd0) begin
            miscompares++;
            $display("FAIL collision_clear: got %h expected 00000000", Busy);
        end
        MarkValid = 1'b1; MarkRg = 5'd0;
        tick();
        MarkValid = 1'b0;
        vectors++;
        if (Busy !== 32'd0) begin
            miscompares++;
            $display("FAIL mark_r0: got %h expected 00000000", Busy);
        end
    endtask

    // Register 0 grant accepted but not written; non-busy grant writes; double mark.
    task automatic test_misc_writes();
        do_reset();
        ReqA_Valid = 1'b1; ReqA_Rg = 5'd0; ReqA_Data = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if (ReqA_Ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rg0_ready: got %b expected 1", ReqA_Ready);
        end
        tick();
        ReqA_Rg = 5'd3; ReqA_Data = 32'h0000_0303;
        MarkValid = 1'b1; MarkRg = 5'd4;
        vectors++;
        if ({RegWrite, Busy} !== {1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL rg0_nowrite: got rw=%b busy=%h expected rw=0 busy=0", RegWrite, Busy);
        end
        tick();
        ReqA_Valid = 1'b0;
        vectors++;
        if ({RegWrite, WriteRg, Busy} !== {1'b1, 5'd3, 32'h0000_0010}) begin
            miscompares++;
            $display("FAIL nonbusy_write: got rw=%b rg=%0d busy=%h expected rw=1 rg=3 busy=00000010",
                     RegWrite, WriteRg, Busy);
        end
        tick();
        MarkValid = 1'b0;
        ReqB_Valid = 1'b1; ReqB_Rg = 5'd4; ReqB_Data = 32'h0000_0404;
        vectors++;
        if (Busy !== 32'h0000_0010) begin
            miscompares++;
            $display("FAIL double_mark: got %h expected 00000010", Busy);
        end
        tick();
        idle_inputs();
        vectors++;
        if ({RegWrite, WriteRg, Busy} !== {1'b1, 5'd4, 32'd0}) begin
            miscompares++;
            $display("FAIL double_mark_clear: got rw=%b rg=%0d busy=%h expected rw=1 rg=4 busy=0",
                     RegWrite, WriteRg, Busy);
        end
    endtask

    // Reset rising in a cycle with a pending request and a loaded scoreboard.
    task automatic test_reset_grant();
        do_reset();
        for (int r = 8; r <= 11; r++) begin
            MarkValid = 1'b1; MarkRg = 5'(r);
            ReqA_Valid = (r == 8); ReqA_Rg = 5'd12; ReqA_Data = 32'h0000_0077;
            tick();
        end
        idle_inputs();
        vectors++;
        if ({Busy, WriteRg} !== {32'h0000_0F00, 5'd12}) begin
            miscompares++;
            $display("FAIL pre_reset_busy: got busy=%h rg=%0d expected busy=00000f00 rg=12", Busy, WriteRg);
        end
        ReqA_Valid = 1'b1; ReqA_Rg = 5'd8; ReqA_Data = 32'h0000_0055;
        ReqB_Valid = 1'b1; ReqB_Rg = 5'd9;
        Reset = 1'b1;
        #1;
        vectors++;
        if ({ReqA_Ready, ReqB_Ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_grant_ready: got %b expected 00", {ReqA_Ready, ReqB_Ready});
        end
        tick();
        vectors++;
        if ({RegWrite, WriteRg, WriteData, Busy} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_grant_state: got rw=%b rg=%0d data=%h busy=%h expected all zero",
                     RegWrite, WriteRg, WriteData, Busy);
        end
        idle_inputs();
        Reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_a();
        test_mark_clear();
        test_contention();
        test_mark_collision();
        test_misc_writes();
        test_reset_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have ports: Clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: ReqA_Valid  input  1  requester A (ALU writeback) has a result.
REQ-004 SHALL have ports: ReqA_Rg  input  5  A destination register.
REQ-005 SHALL have ports: ReqA_Data  input  32  A result.
REQ-006 SHALL have ports: ReqA_Ready  output  1  A transfer accepted this cycle.
REQ-007 SHALL have ports: ReqB_Valid / ReqB_Rg / ReqB_Data / ReqB_Ready  same widths and directions as A; requester B (load/multicycle unit).
REQ-008 SHALL have ports: MarkValid  input  1  issue stage reserves a destination.
REQ-009 SHALL have ports: MarkRg  input  5  register being reserved.
REQ-010 SHALL have ports: RegWrite  output  1  register-bank write enable.
REQ-011 SHALL have ports: WriteRg  output  5  register-bank write address.
REQ-012 SHALL have ports: WriteData  output  32  register-bank write data.
REQ-013 SHALL have ports: Busy  output  32  scoreboard; bit n = register n has a pending write.

Function
REQ-014 Transfer SHALL occur on a requester when Valid and Ready are both 1 at a rising edge; at most one grant per cycle.
REQ-015 ReadyA/ReadyB SHALL be combinational from Valids, arbitration state and Reset; the non-granted Ready SHALL be 0; Ready SHALL be 0 when its Valid is 0.
REQ-016 With a single valid requester, it SHALL be granted in the same cycle.
REQ-017 Contention SHALL be resolved per REQ-032/REQ-033.
REQ-018 Grant in cycle N SHALL drive RegWrite=1, WriteRg, WriteData (registered) during cycle N+1 only; latency exactly 1 cycle.
REQ-019 In a cycle with no grant, RegWrite SHALL be 0; WriteRg/WriteData SHALL hold their previous values.
REQ-020 A granted request with Rg=0 SHALL be accepted (Ready=1) but SHALL produce RegWrite=0.
REQ-021 MarkValid with MarkRg!=0 SHALL set Busy[MarkRg] at the next edge.
REQ-022 Grant with Rg!=0 SHALL clear Busy[Rg] at the next edge.
REQ-023 If the same register is marked and cleared at the same edge, mark SHALL win (Busy stays 1).
REQ-024 Busy[0] SHALL be constant 0; MarkRg=0 SHALL be ignored.
REQ-025 Marking an already-busy register SHALL leave it busy (no counting).
REQ-026 A grant to a non-busy register SHALL still write; Busy stays 0.
REQ-027 Back-to-back grants SHALL produce RegWrite=1 on consecutive cycles, no bubble.

Reset
REQ-028 While Reset=1 at an edge: RegWrite=0, WriteRg=0, WriteData=0, Busy=0, round-robin pointer=A.
REQ-029 While Reset=1, ReqA_Ready=ReqB_Ready=0 (no transfer); Mark inputs ignored.
REQ-030 A grant made in the cycle Reset rises SHALL NOT appear as RegWrite=1.
REQ-031 First grant SHALL be possible in the first cycle with Reset=0.

Configuration
REQ-032 Macro WB_ROUND_ROBIN_EN undefined: fixed priority, A always wins contention; B may starve.
REQ-033 WB_ROUND_ROBIN_EN defined: 1-bit pointer names the preferred requester; on contention the preferred one is granted; after any grant the pointer SHALL point to the other requester; pointer reset value = A.

Verification
REQ-034 Reset then A valid Rg=5 Data=0x0000_00AA -> ReadyA=1 same cycle; next cycle RegWrite=1, WriteRg=5, WriteData=0xAA; following cycle RegWrite=0.
REQ-035 Mark Rg=7 cycle 0; B valid Rg=7 Data=0x1234 cycle 3 -> Busy[7]=1 from cycle 1, 0 from cycle 4; RegWrite=1 WriteRg=7 in cycle 4.
REQ-036 A and B valid 4 cycles (Rg=1/2), no macro -> A granted every cycle, ReadyB=0; with WB_ROUND_ROBIN_EN -> grants A,B,A,B.
REQ-037 Same cycle: Mark Rg=9 and grant Rg=9 with Busy[9]=1 -> Busy[9]=1 after edge; Mark Rg=0 -> Busy=0.
REQ-038 A valid Rg=0 Data=0xFFFF_FFFF -> ReadyA=1, RegWrite stays 0 next cycle.
REQ-039 Busy=0x0000_0F00, A granted, Reset asserted same cycle -> next cycle RegWrite=0, Busy=0, WriteRg=0, both Ready 0 while Reset=1.
